// File: rtl/rpn_sequencer.sv
// Handshaked command sequencer for the 4-bit RPN calculator datapath with stack occupancy tracking.
// Optional stack-clear command enabled by defining RPN_SEQ_CLR_EN.
module rpn_sequencer #(
  parameter int STACK_DEPTH = 32,
  parameter int DEPTH_W     = $clog2(STACK_DEPTH + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cmd_valid,
  input  logic               cmd_func,
  input  logic [1:0]         cmd_op,
  input  logic               cmd_clear,
  input  logic               clear_err,
  output logic               cmd_ready,
  output logic               reg1_en,
  output logic               reg2_en,
  output logic               stack_push,
  output logic               stack_pop,
  output logic               mux_sel,
  output logic [1:0]         alu_op,
  output logic               done,
  output logic               reject,
  output logic               err_ovf,
  output logic               err_unf,
  output logic [DEPTH_W-1:0] depth
);

  localparam logic [DEPTH_W-1:0] DEPTH_ZERO = DEPTH_W'(0);
  localparam logic [DEPTH_W-1:0] DEPTH_ONE  = DEPTH_W'(1);
  localparam logic [DEPTH_W-1:0] DEPTH_TWO  = DEPTH_W'(2);
  localparam logic [DEPTH_W-1:0] DEPTH_FULL = DEPTH_W'(STACK_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_PUSH_IN = 3'd1,
    S_LOAD_A  = 3'd2,
    S_LOAD_B  = 3'd3,
    S_WRITE_R = 3'd4
`ifdef RPN_SEQ_CLR_EN
    ,
    S_CLEAR   = 3'd5
`endif
  } state_t;

  state_t             state_r;
  state_t             state_nxt_s;
  logic               accept_s;
  logic               ovf_set_s;
  logic               unf_set_s;
  logic               op_load_s;
  logic               done_nxt_s;
  logic [DEPTH_W-1:0] depth_nxt_s;

`ifndef RPN_SEQ_CLR_EN
  logic unused_clear_s;
  assign unused_clear_s = cmd_clear;
`endif

  assign accept_s = cmd_valid && (state_r == S_IDLE);

  // Next-state decode, command screening against stack occupancy
  always_comb begin
    state_nxt_s = state_r;
    ovf_set_s   = 1'b0;
    unf_set_s   = 1'b0;
    op_load_s   = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (accept_s) begin
`ifdef RPN_SEQ_CLR_EN
          if (cmd_clear) begin
            state_nxt_s = S_CLEAR;
          end else
`endif
          if (!cmd_func) begin
            if (depth == DEPTH_FULL) begin
              ovf_set_s   = 1'b1;
              state_nxt_s = S_IDLE;
            end else begin
              state_nxt_s = S_PUSH_IN;
            end
          end else begin
            if (depth < DEPTH_TWO) begin
              unf_set_s   = 1'b1;
              state_nxt_s = S_IDLE;
            end else begin
              op_load_s   = 1'b1;
              state_nxt_s = S_LOAD_A;
            end
          end
        end else begin
          state_nxt_s = S_IDLE;
        end
      end
      S_PUSH_IN: state_nxt_s = S_IDLE;
      S_LOAD_A:  state_nxt_s = S_LOAD_B;
      S_LOAD_B:  state_nxt_s = S_WRITE_R;
      S_WRITE_R: state_nxt_s = S_IDLE;
`ifdef RPN_SEQ_CLR_EN
      // The final pop happens in the cycle where depth is still 1.
      S_CLEAR: begin
        if (depth <= DEPTH_ONE) begin
          state_nxt_s = S_IDLE;
        end else begin
          state_nxt_s = S_CLEAR;
        end
      end
`endif
      default: state_nxt_s = S_IDLE;
    endcase
  end

  // Moore strobe decode from the state register
  always_comb begin
    cmd_ready  = 1'b0;
    reg1_en    = 1'b0;
    reg2_en    = 1'b0;
    stack_push = 1'b0;
    stack_pop  = 1'b0;
    mux_sel    = 1'b0;
    case (state_r)
      S_IDLE:    cmd_ready = 1'b1;
      S_PUSH_IN: stack_push = 1'b1;
      S_LOAD_A: begin
        reg1_en   = 1'b1;
        stack_pop = 1'b1;
      end
      S_LOAD_B: begin
        reg2_en   = 1'b1;
        stack_pop = 1'b1;
      end
      S_WRITE_R: begin
        stack_push = 1'b1;
        mux_sel    = 1'b1;
      end
`ifdef RPN_SEQ_CLR_EN
      S_CLEAR:   stack_pop = (depth != DEPTH_ZERO);
`endif
      default: begin
        cmd_ready = 1'b0;
      end
    endcase
  end

  // Occupancy bookkeeping and completion detection, saturating at both ends
  always_comb begin
    depth_nxt_s = depth;
    done_nxt_s  = 1'b0;
    case (state_r)
      S_PUSH_IN, S_WRITE_R: begin
        done_nxt_s = 1'b1;
        if (depth != DEPTH_FULL) begin
          depth_nxt_s = depth + DEPTH_ONE;
        end else begin
          depth_nxt_s = depth;
        end
      end
      S_LOAD_A, S_LOAD_B: begin
        if (depth != DEPTH_ZERO) begin
          depth_nxt_s = depth - DEPTH_ONE;
        end else begin
          depth_nxt_s = depth;
        end
      end
`ifdef RPN_SEQ_CLR_EN
      S_CLEAR: begin
        done_nxt_s = (depth <= DEPTH_ONE);
        if (depth != DEPTH_ZERO) begin
          depth_nxt_s = depth - DEPTH_ONE;
        end else begin
          depth_nxt_s = depth;
        end
      end
`endif
      default: begin
        depth_nxt_s = depth;
        done_nxt_s  = 1'b0;
      end
    endcase
  end

  // State, occupancy, pulses, sticky flags and latched opcode
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= S_IDLE;
      depth   <= DEPTH_ZERO;
      done    <= 1'b0;
      reject  <= 1'b0;
      err_ovf <= 1'b0;
      err_unf <= 1'b0;
      alu_op  <= 2'b00;
    end else begin
      state_r <= state_nxt_s;
      depth   <= depth_nxt_s;
      done    <= done_nxt_s;
      reject  <= ovf_set_s | unf_set_s;
      // Setting wins over a simultaneous clear.
      err_ovf <= ovf_set_s | (err_ovf & ~clear_err);
      err_unf <= unf_set_s | (err_unf & ~clear_err);
      if (op_load_s) begin
        alu_op <= cmd_op;
      end else begin
        alu_op <= alu_op;
      end
    end
  end

endmodule
